// File: rtl/xadc_cfg_pkg.sv
// xadc_cfg_pkg: DRP addresses, configuration table and FSM state type for xadc_drp_writer.
//   ADDR_TBL/DATA_TBL : 16-entry address/data table; entries past the six real
//                       registers repeat the last write so NUM_WORDS up to 16 stays safe.
//   state_t           : writer FSM states.
package xadc_cfg_pkg;
  localparam logic [6:0] CFG0     = 7'h40;
  localparam logic [6:0] CFG1     = 7'h41;
  localparam logic [6:0] CFG2     = 7'h42;
  localparam logic [6:0] SEQ_CH0  = 7'h48;
  localparam logic [6:0] SEQ_CH1  = 7'h49;
  localparam logic [6:0] SEQ_AVG0 = 7'h4A;
  localparam int TBL_DEPTH = 16;
  // CFG0: 16-sample averaging; CFG1: SEQ=0010 continuous sequence mode; CFG2: dclk divide by 4.
  // SEQ_CH0 enables temp, vccint, vccaux, vp/vn, vccbram (5) and SEQ_CH1 enables aux 0..7 (8): 13 channels.
  localparam logic [6:0] ADDR_TBL [TBL_DEPTH] = '{
    CFG0, CFG1, CFG2, SEQ_CH0, SEQ_CH1, SEQ_AVG0,
    SEQ_AVG0, SEQ_AVG0, SEQ_AVG0, SEQ_AVG0, SEQ_AVG0,
    SEQ_AVG0, SEQ_AVG0, SEQ_AVG0, SEQ_AVG0, SEQ_AVG0};
  localparam logic [15:0] DATA_TBL [TBL_DEPTH] = '{
    16'h1000, 16'h2000, 16'h0400, 16'h4F00, 16'h00FF, 16'h0100,
    16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
    16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100};
  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, DONE, ERROR} state_t;
endpackage

// File: rtl/xadc_drp_timeout.sv
// drp_timeout_counter: per-access wait counter for the DRP writer.
//   clk, rst (async active-low), load (ISSUE cycle), count (WAIT cycle),
//   expired: the count reaches TIMEOUT at the end of the current cycle.
module drp_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expired
);
  logic [7:0] cnt;
  // The den cycle is the first waiting cycle, so load starts the count at 1.
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (load) cnt <= 8'd1;
    else if (count && cnt != 8'hFF) cnt <= cnt + 8'd1;
  assign expired = 9'(cnt) + 9'd1 == 9'(TIMEOUT);
endmodule

// File: rtl/xadc_drp_writer.sv
// xadc_drp_writer: walks the XADC configuration table over the DRP port after reset.
//   clk/rst (async active-low), start (rerun from DONE/ERROR),
//   daddr_out/den_out/dwe_out/di_out/do_in/drdy_in: DRP port,
//   busy/done/error/err_addr: status to the top level.
//   Define XADC_CFG_VERIFY_EN to read back and compare every written register.
module xadc_drp_writer
  import xadc_cfg_pkg::*;
#(
  parameter int NUM_WORDS = 6,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [6:0]  daddr_out,
  output logic        den_out,
  output logic        dwe_out,
  output logic [15:0] di_out,
  input  logic [15:0] do_in,
  input  logic        drdy_in,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [6:0]  err_addr
);
  state_t     state;
  logic [3:0] idx;
  logic       last, tmo_load, tmo_count, tmo_expired;
  assign last      = idx == 4'(NUM_WORDS - 1);
  assign tmo_load  = state == WR_ISSUE || state == RD_ISSUE;
  assign tmo_count = state == WR_WAIT || state == RD_WAIT;
  drp_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(clk), .rst(rst), .load(tmo_load), .count(tmo_count), .expired(tmo_expired)
  );
`ifndef XADC_CFG_VERIFY_EN
  logic unused_do;
  assign unused_do = ^do_in;
`endif
  // Outputs are registered from the current state, so they trail the state by one cycle.
  // done/error drop in the cycle after a start pulse is sampled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      daddr_out <= '0;
      den_out   <= 1'b0;
      dwe_out   <= 1'b0;
      di_out    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_addr  <= '0;
    end else begin
      den_out <= tmo_load;
      dwe_out <= state == WR_ISSUE;
      busy    <= state inside {WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT};
      done    <= state == DONE && !start;
      error   <= state == ERROR && !start;
      if (tmo_load) daddr_out <= ADDR_TBL[idx];
      if (state == WR_ISSUE) di_out <= DATA_TBL[idx];
      if (state == ERROR) err_addr <= ADDR_TBL[idx];
      case (state)
        IDLE: begin
          state <= WR_ISSUE;
          idx   <= '0;
        end
        WR_ISSUE: state <= WR_WAIT;
        WR_WAIT:
          if (drdy_in) begin
`ifdef XADC_CFG_VERIFY_EN
            state <= RD_ISSUE;
`else
            state <= last ? DONE : WR_ISSUE;
            idx   <= last ? idx : idx + 4'd1;
`endif
          end else if (tmo_expired) state <= ERROR;
`ifdef XADC_CFG_VERIFY_EN
        RD_ISSUE: state <= RD_WAIT;
        RD_WAIT:
          if (drdy_in) begin
            state <= do_in != DATA_TBL[idx] ? ERROR : last ? DONE : WR_ISSUE;
            idx   <= do_in != DATA_TBL[idx] || last ? idx : idx + 4'd1;
          end else if (tmo_expired) state <= ERROR;
`endif
        DONE, ERROR:
          if (start) begin
            state <= WR_ISSUE;
            idx   <= '0;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xadc_drp_writer.sv
// tb_xadc_drp_writer: directed bench for xadc_drp_writer with a behavioural DRP register model.
module tb_xadc_drp_writer;
  localparam int T = 255;
`ifdef XADC_CFG_VERIFY_EN
  localparam int ACC = 2;
`else
  localparam int ACC = 1;
`endif
  localparam int WORD_CYC = 4 * ACC;
  typedef struct {int cyc; logic [6:0] addr; logic we; logic [15:0] data;} acc_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, drdy_in = 1'b0;
  logic [15:0] do_in = '0;
  logic [6:0] daddr_out, err_addr;
  logic den_out, dwe_out, busy, done, error;
  logic [15:0] di_out;
  int checks = 0, errors = 0;
  logic [6:0] exp_addr [6] = '{7'h40, 7'h41, 7'h42, 7'h48, 7'h49, 7'h4A};
  logic [15:0] exp_data [6] = '{16'h1000, 16'h2000, 16'h0400, 16'h4F00, 16'h00FF, 16'h0100};
  xadc_drp_writer #(.NUM_WORDS(6), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .start(start), .daddr_out(daddr_out), .den_out(den_out),
    .dwe_out(dwe_out), .di_out(di_out), .do_in(do_in), .drdy_in(drdy_in),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr)
  );
  always #5 clk = ~clk;
  // DRP model: answers each access after a programmable number of cycles, keeps a register
  // image for read-back and logs every den pulse with the cycle it was high in.
  acc_t log_q [$];
  logic [15:0] regs [128];
  int cyc = 0, pend = 0, dwe_bad = 0, slow_k = 1;
  logic [6:0] p_addr = '0, stall_addr = '0, slow_addr = '0, corrupt_addr = '0;
  logic p_we = 1'b0;
  always @(posedge clk) begin
    logic fire;
    cyc++;
    fire = pend == 1;
    if (pend > 0) pend--;
    if (dwe_out && !den_out) dwe_bad++;
    if (den_out) begin
      log_q.push_back('{cyc - 1, daddr_out, dwe_out, di_out});
      p_addr = daddr_out;
      p_we = dwe_out;
      if (dwe_out) regs[daddr_out] = di_out;
      if (!(dwe_out && daddr_out == stall_addr))
        pend = (dwe_out && daddr_out == slow_addr) ? slow_k : 1;
    end
    #1;
    drdy_in = fire;
    do_in = (fire && !p_we) ? regs[p_addr] ^ {15'd0, p_addr == corrupt_addr} : 16'd0;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  function automatic acc_t wr(input int s, input int n);
    int k = 0;
    wr = '{-1000, 7'h7F, 1'b0, 16'h0};
    for (int i = s; i < log_q.size(); i++)
      if (log_q[i].we) begin
        if (k == n) return log_q[i];
        k++;
      end
  endfunction
  function automatic int n_writes(input int s);
    n_writes = 0;
    for (int i = s; i < log_q.size(); i++) if (log_q[i].we) n_writes++;
  endfunction
  task automatic wait_for(input bit on_error, input int max, output int at);
    at = -1;
    for (int i = 0; i < max && at < 0; i++) begin
      @(negedge clk);
      if ((on_error ? error : done) === 1'b1) at = cyc;
    end
  endtask
  task automatic do_reset(output int rel);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rel = cyc;
  endtask
  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({den_out, dwe_out, busy, done, error} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {den_out, dwe_out, busy, done, error});
    end
    checks++;
    if ({daddr_out, di_out, err_addr} !== 30'h0) begin
      errors++; $display("FAIL reset_data: got daddr=%h di=%h err_addr=%h expected 0", daddr_out, di_out, err_addr);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (den_out !== 1'b0 || log_q.size() != 0) begin
      errors++; $display("FAIL reset_hold: den=%b accesses=%0d expected 0/0", den_out, log_q.size());
    end
  endtask

  task automatic test_sequence;
    int rel, s, at;
    acc_t a, f;
    s = log_q.size();
    @(negedge clk);
    rst = 1'b1;
    rel = cyc;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL seq_busy: got %b expected 1", busy); end
    wait_for(1'b0, 1000, at);
    checks++;
    if (at < 0) begin errors++; $display("FAIL seq_done_timeout: done got 0 expected 1"); end
    f = wr(s, 0);
    checks++;
    if (f.cyc != rel + 2) begin errors++; $display("FAIL seq_first_den: got cycle %0d expected %0d", f.cyc, rel + 2); end
    for (int i = 0; i < 6; i++) begin
      a = wr(s, i);
      checks++;
      if (a.addr !== exp_addr[i] || a.data !== exp_data[i] || a.cyc != f.cyc + i * WORD_CYC) begin
        errors++;
        $display("FAIL seq_word%0d: got addr=%h data=%h cyc+%0d expected addr=%h data=%h cyc+%0d",
                 i, a.addr, a.data, a.cyc - f.cyc, exp_addr[i], exp_data[i], i * WORD_CYC);
      end
    end
    checks++;
    if (n_writes(s) != 6) begin errors++; $display("FAIL seq_nwrites: got %0d expected 6", n_writes(s)); end
    checks++;
    if (at - f.cyc != 6 * WORD_CYC) begin errors++; $display("FAIL seq_done_time: got %0d expected %0d", at - f.cyc, 6 * WORD_CYC); end
    checks++;
    if (busy !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL seq_status: got busy=%b error=%b expected 0/0", busy, error); end
    checks++;
    if (dwe_bad != 0) begin errors++; $display("FAIL seq_dwe_without_den: got %0d expected 0", dwe_bad); end
  endtask

  task automatic test_start_busy;
    int rel, s, at;
    s = log_q.size();
    do_reset(rel);
    repeat (6) @(negedge clk);
    pulse_start();
    wait_for(1'b0, 1000, at);
    checks++;
    if (n_writes(s) != 6 || wr(s, 0).cyc != rel + 2) begin
      errors++; $display("FAIL busy_start_seq: got writes=%0d first=%0d expected 6/%0d", n_writes(s), wr(s, 0).cyc, rel + 2);
    end
    checks++;
    if (at - wr(s, 0).cyc != 6 * WORD_CYC) begin
      errors++; $display("FAIL busy_start_time: got %0d expected %0d", at - wr(s, 0).cyc, 6 * WORD_CYC);
    end
  endtask

  task automatic test_start_done;
    int s, c0, at;
    s = log_q.size();
    pulse_start();
    c0 = cyc;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_clear: got %b expected 0", done); end
    wait_for(1'b0, 1000, at);
    checks++;
    if (wr(s, 0).addr !== 7'h40 || wr(s, 0).cyc != c0 + 1) begin
      errors++; $display("FAIL replay_first: got addr=%h cyc=%0d expected 40/%0d", wr(s, 0).addr, wr(s, 0).cyc, c0 + 1);
    end
    checks++;
    if (n_writes(s) != 6 || at - wr(s, 0).cyc != 6 * WORD_CYC) begin
      errors++; $display("FAIL replay_run: got writes=%0d time=%0d expected 6/%0d", n_writes(s), at - wr(s, 0).cyc, 6 * WORD_CYC);
    end
  endtask

  task automatic test_timeout;
    int rel, s, at, n;
    stall_addr = 7'h42;
    s = log_q.size();
    do_reset(rel);
    wait_for(1'b1, 2000, at);
    checks++;
    if (at - wr(s, 2).cyc != T) begin errors++; $display("FAIL tmo_time: got %0d expected %0d", at - wr(s, 2).cyc, T); end
    checks++;
    if (err_addr !== 7'h42) begin errors++; $display("FAIL tmo_err_addr: got %h expected 42", err_addr); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL tmo_status: got busy=%b done=%b expected 0/0", busy, done); end
    n = log_q.size();
    repeat (10) @(negedge clk);
    checks++;
    if (log_q.size() != n) begin errors++; $display("FAIL tmo_quiet: got %0d extra accesses expected 0", log_q.size() - n); end
    stall_addr = 7'h00;
    pulse_start();
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL tmo_error_clear: got %b expected 0", error); end
    wait_for(1'b0, 1000, at);
    checks++;
    if (at < 0 || n_writes(n) != 6 || wr(n, 0).addr !== 7'h40) begin
      errors++; $display("FAIL tmo_restart: got done_at=%0d writes=%0d first=%h expected done/6/40", at, n_writes(n), wr(n, 0).addr);
    end
  endtask

  task automatic test_timeout_boundary;
    int rel, s, at;
    slow_addr = 7'h41;
    slow_k = T - 3;
    s = log_q.size();
    do_reset(rel);
    wait_for(1'b0, 2000, at);
    checks++;
    if (at < 0 || error !== 1'b0) begin errors++; $display("FAIL edge_accept: got done_at=%0d error=%b expected done/0", at, error); end
    checks++;
    if (at - wr(s, 0).cyc != 6 * WORD_CYC + T - 4) begin
      errors++; $display("FAIL edge_time: got %0d expected %0d", at - wr(s, 0).cyc, 6 * WORD_CYC + T - 4);
    end
    slow_k = T - 2;
    s = log_q.size();
    do_reset(rel);
    wait_for(1'b1, 2000, at);
    checks++;
    if (at - wr(s, 1).cyc != T || err_addr !== 7'h41) begin
      errors++; $display("FAIL late_drdy: got time=%0d err_addr=%h expected %0d/41", at - wr(s, 1).cyc, err_addr, T);
    end
    slow_addr = 7'h00;
    slow_k = 1;
  endtask

  task automatic test_reset_mid_access;
    int rel, s, at, t;
    slow_addr = 7'h41;
    slow_k = 4;
    do_reset(rel);
    t = -1;
    for (int i = 0; i < 100 && t < 0; i++) begin
      @(negedge clk);
      if (den_out && dwe_out && daddr_out == 7'h41) t = cyc;
    end
    repeat (2) @(negedge clk);
    slow_addr = 7'h00;
    slow_k = 1;
    rst = 1'b0;
    #1;
    checks++;
    if ({den_out, dwe_out, busy, done, error} !== 5'b0 || {daddr_out, di_out, err_addr} !== 30'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got ctrl=%b daddr=%h di=%h err_addr=%h expected 0",
               {den_out, dwe_out, busy, done, error}, daddr_out, di_out, err_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    s = log_q.size();
    wait_for(1'b0, 1000, at);
    checks++;
    if (t < 0 || wr(s, 0).addr !== 7'h40 || wr(s, 0).cyc != t + 6) begin
      errors++; $display("FAIL midreset_restart: got addr=%h cyc=%0d expected 40/%0d", wr(s, 0).addr, wr(s, 0).cyc, t + 6);
    end
    checks++;
    if (n_writes(s) != 6 || at - wr(s, 0).cyc != 6 * WORD_CYC) begin
      errors++; $display("FAIL midreset_run: got writes=%0d time=%0d expected 6/%0d", n_writes(s), at - wr(s, 0).cyc, 6 * WORD_CYC);
    end
  endtask

`ifdef XADC_CFG_VERIFY_EN
  task automatic test_verify;
    int rel, s, at, n;
    corrupt_addr = 7'h48;
    s = log_q.size();
    do_reset(rel);
    wait_for(1'b1, 2000, at);
    checks++;
    if (at < 0 || err_addr !== 7'h48 || busy !== 1'b0) begin
      errors++; $display("FAIL verify_err: got at=%0d err_addr=%h busy=%b expected error/48/0", at, err_addr, busy);
    end
    checks++;
    if (n_writes(s) != 4 || log_q[log_q.size() - 1].we !== 1'b0 || log_q[log_q.size() - 1].addr !== 7'h48) begin
      errors++; $display("FAIL verify_last_access: got writes=%0d expected 4 ending with read of 48", n_writes(s));
    end
    n = log_q.size();
    repeat (10) @(negedge clk);
    checks++;
    if (log_q.size() != n) begin errors++; $display("FAIL verify_quiet: got %0d extra accesses expected 0", log_q.size() - n); end
    corrupt_addr = 7'h00;
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_start_busy();
    test_start_done();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid_access();
`ifdef XADC_CFG_VERIFY_EN
    test_verify();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
